// File: rtl/univ_shift_ctrl_pkg.sv
// Shared types and constants for the universal shift register sequencing controller.
package univ_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    FIN   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    LOGIC = 2'b00,
    ARITH = 2'b01,
    ROT   = 2'b10
  } mode_e;

  // Select encoding is {S0, S1}
  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  // Reserved request mode 2'b11 folds onto logical
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = ARITH;
      2'b10:   decode_mode = ROT;
      default: decode_mode = LOGIC;
    endcase
  endfunction

endpackage

// File: rtl/univ_shift_ctrl_if.sv
// Request handshake bundle between a requester and univ_shift_ctrl.
interface univ_shift_ctrl_if #(
  parameter int C_BIT_NUM = 24
);
  localparam int C_AMT_W = $clog2(C_BIT_NUM + 1);

  logic                 REQ_VALID;
  logic                 REQ_READY;
  logic [C_BIT_NUM-1:0] REQ_DATA;
  logic                 REQ_DIR;
  logic [1:0]           REQ_MODE;
  logic [C_AMT_W-1:0]   REQ_AMT;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_DIR, REQ_MODE, REQ_AMT,
    input  REQ_READY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_DIR, REQ_MODE, REQ_AMT,
    output REQ_READY
  );
endinterface

// File: rtl/univ_shift_ctrl_shift_amt_cnt.sv
// Loadable down counter holding the remaining shift count, with zero flag.
module shift_amt_cnt #(
  parameter int C_AMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [C_AMT_W-1:0] load_val,
  input  logic               dec,
  output logic [C_AMT_W-1:0] cnt,
  output logic               zero
);

  logic [C_AMT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - C_AMT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/univ_shift_ctrl.sv
// Sequences one parallel load followed by N single-bit shifts on a downstream
// universal shift register, sourcing rotate/arithmetic fill bits from its Q.
module univ_shift_ctrl
  import univ_shift_pkg::*;
#(
  parameter  int C_BIT_NUM = 24,
  localparam int C_AMT_W   = $clog2(C_BIT_NUM + 1)
) (
  input  logic                 CK,
  input  logic                 RST,
  univ_shift_ctrl_if.slave     req,
  input  logic [C_BIT_NUM-1:0] Q_IN,
  output logic                 S0,
  output logic                 S1,
  output logic                 SLI,
  output logic                 SRI,
  output logic [C_BIT_NUM-1:0] D,
  output logic                 BUSY,
  output logic                 DONE
);

  state_e               state_d, state_q;
  logic [C_BIT_NUM-1:0] d_d, d_q;
  logic                 dir_d, dir_q;
  mode_e                mode_d, mode_q;

  logic [C_AMT_W-1:0]   amt_clamped;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [C_AMT_W-1:0]   cnt;
  logic                 ready;
  logic [1:0]           sel;
  logic                 q_mid_unused;

  assign amt_clamped = (req.REQ_AMT > C_AMT_W'(C_BIT_NUM)) ? C_AMT_W'(C_BIT_NUM)
                                                           : req.REQ_AMT;

  // Readiness is state-decoded but also forced low while reset is held
  assign ready         = (state_q == IDLE) && !RST;
  assign req.REQ_READY = ready;

  shift_amt_cnt #(.C_AMT_W(C_AMT_W)) u_amt_cnt (
    .clk      (CK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (amt_clamped),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.REQ_VALID && ready) begin
          d_d      = req.REQ_DATA;
          dir_d    = req.REQ_DIR;
          mode_d   = decode_mode(req.REQ_MODE);
          cnt_load = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD:    state_d = cnt_zero ? FIN : SHIFT;
      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt == C_AMT_W'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      d_q     <= '0;
      dir_q   <= 1'b0;
      mode_q  <= LOGIC;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    sel = SEL_HOLD;
    case (state_q)
      LOAD:    sel = SEL_LOAD;
      SHIFT:   sel = dir_q ? SEL_RIGHT : SEL_LEFT;
      default: sel = SEL_HOLD;
    endcase
  end

  assign S0   = sel[1];
  assign S1   = sel[0];
  assign D    = d_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == FIN);

  // Only the serial input on the active shift side carries a fill bit
  always_comb begin
    SLI = 1'b0;
    SRI = 1'b0;
    case (mode_q)
      ARITH: SRI = dir_q & Q_IN[C_BIT_NUM-1];
      ROT: begin
        SLI = ~dir_q & Q_IN[C_BIT_NUM-1];
        SRI =  dir_q & Q_IN[0];
      end
      default: ;
    endcase
  end

  assign q_mid_unused = ^Q_IN[C_BIT_NUM-2:1];

endmodule

// File: tb/tb_univ_shift_ctrl.sv
// Directed bench: controller driving a behavioural 24-bit universal shift register.
module tb_univ_shift_ctrl;

  localparam int W  = 24;
  localparam int AW = $clog2(W + 1);

  logic          CK = 1'b0;
  logic          RST;
  logic          S0, S1, SLI, SRI, BUSY, DONE;
  logic [W-1:0]  D;
  logic [W-1:0]  q_reg;

  int errors = 0;
  int checks = 0;

  univ_shift_ctrl_if #(.C_BIT_NUM(W)) req_if ();

  univ_shift_ctrl #(.C_BIT_NUM(W)) dut (
    .CK   (CK),
    .RST  (RST),
    .req  (req_if.slave),
    .Q_IN (q_reg),
    .S0   (S0),
    .S1   (S1),
    .SLI  (SLI),
    .SRI  (SRI),
    .D    (D),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CK = ~CK;

  // Downstream universal shift register
  always @(posedge CK) begin
    case ({S0, S1})
      2'b01:   q_reg <= {q_reg[W-2:0], SLI};
      2'b10:   q_reg <= {SRI, q_reg[W-1:1]};
      2'b11:   q_reg <= D;
      default: q_reg <= q_reg;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [W-1:0] data, input logic dir,
                         input logic [1:0] mode, input logic [AW-1:0] amt);
    req_if.REQ_DATA = data;
    req_if.REQ_DIR  = dir;
    req_if.REQ_MODE = mode;
    req_if.REQ_AMT  = amt;
  endtask

  // Accept on the next edge; leaves the bench #1 after the accept edge
  task automatic accept(input string tag, input logic [W-1:0] data, input logic dir,
                        input logic [1:0] mode, input logic [AW-1:0] amt);
    @(negedge CK);
    set_req(data, dir, mode, amt);
    req_if.REQ_VALID = 1'b1;
    #1 chk({tag, "_ready"}, 32'(req_if.REQ_READY), 32'd1);
    @(posedge CK);
    #1 req_if.REQ_VALID = 1'b0;
    chk({tag, "_load_sel"}, 32'({S0, S1}), 32'd3);
    chk({tag, "_load_d"}, 32'(D), 32'(data));
  endtask

  task automatic run_req(input string tag, input logic [W-1:0] data, input logic dir,
                         input logic [1:0] mode, input logic [AW-1:0] amt,
                         input logic [W-1:0] exp_q);
    int n;
    int amt_c;
    amt_c = (int'(amt) > W) ? W : int'(amt);
    accept(tag, data, dir, mode, amt);
    n = 0;
    while (!DONE && n < 60) begin
      @(posedge CK);
      #1 n++;
    end
    // DONE appears in cycle k+2+amt, i.e. amt+1 edges after the accept edge
    chk({tag, "_lat"}, 32'(n), 32'(amt_c + 1));
    chk({tag, "_q"}, 32'(q_reg), 32'(exp_q));
    chk({tag, "_fin_busy"}, 32'(BUSY), 32'd1);
    @(posedge CK);
    #1 chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    chk({tag, "_ready_after"}, 32'(req_if.REQ_READY), 32'd1);
  endtask

  initial begin
    int i;
    int done_seen;
    logic [W-1:0] q_first;

    req_if.REQ_VALID = 1'b0;
    set_req('0, 1'b0, 2'b00, '0);
    RST = 1'b1;
    #22;
    chk("rst_sel", 32'({S0, S1}), 32'd0);
    chk("rst_fill", 32'({SLI, SRI}), 32'd0);
    chk("rst_d", 32'(D), 32'd0);
    chk("rst_busy_done", 32'({BUSY, DONE}), 32'd0);
    chk("rst_ready", 32'(req_if.REQ_READY), 32'd0);
    @(negedge CK) RST = 1'b0;
    #1 chk("post_rst_ready", 32'(req_if.REQ_READY), 32'd1);

    run_req("lsl4", 24'h000001, 1'b0, 2'b00, 5'd4, 24'h000010);
    run_req("asr3", 24'h800000, 1'b1, 2'b01, 5'd3, 24'hF00000);
    run_req("ror1", 24'h000003, 1'b1, 2'b10, 5'd1, 24'h800001);
    run_req("ror0", 24'h000003, 1'b1, 2'b10, 5'd0, 24'h000003);
    run_req("rol1", 24'h800000, 1'b0, 2'b10, 5'd1, 24'h000001);
    run_req("rsv4", 24'h800000, 1'b1, 2'b11, 5'd4, 24'h080000);
    run_req("clamp", 24'hFFFFFF, 1'b0, 2'b00, 5'd31, 24'h000000);

    // Reset in the middle of a 10-shift request
    accept("abort", 24'h000001, 1'b0, 2'b00, 5'd10);
    repeat (5) @(posedge CK);
    #2 RST = 1'b1;
    #1 chk("abort_sel", 32'({S0, S1}), 32'd0);
    chk("abort_busy_done", 32'({BUSY, DONE}), 32'd0);
    chk("abort_d", 32'(D), 32'd0);
    chk("abort_ready", 32'(req_if.REQ_READY), 32'd0);
    @(negedge CK) RST = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge CK);
      #1 if (DONE) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_ready_after", 32'(req_if.REQ_READY), 32'd1);

    // Back-pressure: VALID held high, second request accepted at edge k+3+amt
    accept("bp1", 24'h00000F, 1'b0, 2'b00, 5'd2);
    req_if.REQ_VALID = 1'b1;
    q_first = '0;
    i = 0;
    do begin
      @(negedge CK);
      i++;
      if (DONE) q_first = q_reg;
    end while (!req_if.REQ_READY && i < 40);
    chk("bp_ready_gap", 32'(i), 32'd5);
    chk("bp1_q", 32'(q_first), 32'h00003C);
    set_req(24'h000100, 1'b1, 2'b00, 5'd8);
    @(posedge CK);
    #1 req_if.REQ_VALID = 1'b0;
    chk("bp2_load_d", 32'(D), 32'h000100);
    i = 0;
    while (!DONE && i < 60) begin
      @(posedge CK);
      #1 i++;
    end
    chk("bp2_lat", 32'(i), 32'd9);
    chk("bp2_q", 32'(q_reg), 32'h000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
